systolic_seq_ctrl: RTL
======================

Name: systolic_seq_ctrl

Overview:
Sequencer for an N x N systolic array of accumulate-until-finished MAC PEs. On a start command it clears the array and issues skewed read addresses to the row-edge (A) and column-edge (B) operand buffers. It drives per-row and per-column finished flags, aligned to buffer read latency, so every PE latches C_out, then signals done. It owns only the schedule; the operand SRAMs and the PE grid sit outside it.

Parameters:
N, 4, array dimension (rows = columns = N)
K_W, 8, width of dot-product length k_len
ADDR_W, 8, operand buffer address width (must be at least K_W)
RD_LAT, 1, operand buffer read latency in cycles (0..3)

Ports:
clk  in  1  clock
rst  in  1  reset: rst, synchronous, active-high; clock clk
start  in  1  start command, sampled in IDLE only
k_len  in  K_W  accumulate steps per PE, sampled with start
busy  out  1  high from CLEAR through DONE inclusive
done  out  1  one-cycle pulse in DONE
mac_clr  out  1  one-cycle array clear (drives PE rst)
a_rd_en  out  N  row i buffer read enable
a_rd_addr  out  N*ADDR_W  row i read address, slice i
b_rd_en  out  N  column j buffer read enable
b_rd_addr  out  N*ADDR_W  column j read address, slice j
a_fin  out  N  row i finished flag, aligned to read data (delayed RD_LAT)
b_fin  out  N  column j finished flag, aligned to read data
a_zero  out  N  row i edge data must be forced to 0 (delayed RD_LAT)
b_zero  out  N  column j edge data must be forced to 0

Behaviour:
- Reset: state IDLE; all outputs 0; counters, latched k_len and delay pipelines cleared. rst mid-operation aborts at once; no done pulse.
- FSM states:
  - IDLE: start=1 with k_len!=0 -> CLEAR, latch K=k_len. start with k_len==0 is ignored and stays IDLE. a_fin/b_fin/a_zero/b_zero hold their last values in IDLE so the array keeps C_out.
  - CLEAR (1 cycle): mac_clr=1; fin/zero schedule and delay pipelines cleared; t<=0 -> FEED.
  - FEED (K+N-1 cycles, t=0..K+N-2):
    - lane i (same rule for rows and columns) has rd_en=1 and addr=t-i when i<=t<i+K; otherwise rd_en=0 and addr=0.
    - schedule zero_s[i]=1 when t<i or t>=i+K; fin_s[i]=1 when t>=i+K.
    - after t=K+N-2 -> DRAIN.
  - DRAIN (RD_LAT+2N-1 cycles): rd_en=0; fin_s=zero_s=all ones; then -> DONE.
  - DONE (1 cycle): done=1 -> IDLE.
- a_fin/a_zero = fin_s/zero_s delayed exactly RD_LAT cycles (RD_LAT=0: combinational pass). b_* use the identical schedule per column.
- Latency: start in cycle 0 gives done in cycle 1+(K+N-1)+(RD_LAT+2N-1)+1 = K+3N+RD_LAT.
- start while busy is ignored. Addresses never exceed K-1, so there is no wrap.
- Counter t is K_W+$clog2(N)+1 bits wide; k_len=2^K_W-1 must not overflow.

Decomposition:
- systolic_pkg: state enum (IDLE, CLEAR, FEED, DRAIN, DONE), default N, and the helper constant for drain length (RD_LAT+2N-1).
- Sub-module lane_delay: RD_LAT-stage shift register, parameterised width, sync clear input. It is instantiated once for {fin_s, zero_s} of rows and once for columns.

Test Plan:
- N=4, RD_LAT=1, k_len=3, start in cycle 0 -> mac_clr in cycle 1; a_rd_en[0] in cycles 2-4 with addr 0,1,2; a_rd_en[3] in cycles 5-7; done in cycle 16; busy high in cycles 1-16.
- Same config -> a_fin[0] rises in cycle 6 and a_fin[3] in cycle 9, both held through IDLE; a_zero[3]=1 in cycles 3-5 and again from cycle 9. With the full array plus SRAM model, C = A*B matches a golden 4x4 matmul.
- k_len=0 start -> busy stays 0, no mac_clr, no done; a following k_len=1 start -> done after 1+3*4+1 = 14 cycles.
- start pulsed again in cycles 5 and 10 during a k_len=3 run -> ignored; exactly one done, in cycle 16.
- rst asserted in cycle 7 of a run -> next cycle all outputs 0 and IDLE; no done; a new start completes normally.
- RD_LAT=0 and RD_LAT=3 builds, k_len=255 -> fin aligned to the address schedule plus RD_LAT; done in cycle 255+12+RD_LAT; t counter does not overflow.

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM states and schedule constants for the systolic sequencer
package systolic_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
    localparam int N_DEF = 4;
    function automatic int drain_len(input int rd_lat, input int n);
        return rd_lat + 2 * n - 1;
    endfunction
endpackage

// File: rtl/lane_delay.sv
// lane_delay: LAT-stage shift register aligning schedule flags to operand read data
module lane_delay #(
    parameter int W   = 1,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    generate
        if (LAT == 0) begin : g_pass
            assign q = d;
        end else begin : g_pipe
            logic [W-1:0] sr [LAT];
            // shift toward the output; clr empties every stage at once
            always_ff @(posedge clk) begin
                if (clr) begin
                    for (int s = 0; s < LAT; s++) sr[s] <= '0;
                end else begin
                    sr[0] <= d;
                    for (int s = 1; s < LAT; s++) sr[s] <= sr[s-1];
                end
            end
            assign q = sr[LAT-1];
        end
    endgenerate
endmodule

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: clear/feed/drain schedule for an N x N accumulate-until-finished MAC array
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int K_W    = 8,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [K_W-1:0]      k_len,
    output logic                busy,
    output logic                done,
    output logic                mac_clr,
    output logic [N-1:0]        a_rd_en,
    output logic [N*ADDR_W-1:0] a_rd_addr,
    output logic [N-1:0]        b_rd_en,
    output logic [N*ADDR_W-1:0] b_rd_addr,
    output logic [N-1:0]        a_fin,
    output logic [N-1:0]        b_fin,
    output logic [N-1:0]        a_zero,
    output logic [N-1:0]        b_zero
);
    localparam int TW = K_W + $clog2(N) + 1;
    localparam int DL = drain_len(RD_LAT, N);

    state_t              state;
    logic [TW-1:0]       t, nt;
    logic [K_W-1:0]      k;
    logic [N-1:0]        rd_en, fin_s, zero_s, nx_en, nx_fin, nx_zero;
    logic [N*ADDR_W-1:0] addr, nx_addr;

    // schedule for the feed step that the next cycle will present
    always_comb begin
        nt      = state == CLEAR ? '0 : t + 1'b1;
        nx_en   = '0;
        nx_fin  = '0;
        nx_zero = '0;
        nx_addr = '0;
        for (int i = 0; i < N; i++) begin
            nx_en[i]                    = nt >= TW'(i) && nt < TW'(i) + TW'(k);
            nx_fin[i]                   = nt >= TW'(i) + TW'(k);
            nx_zero[i]                  = !nx_en[i];
            nx_addr[i*ADDR_W +: ADDR_W] = nx_en[i] ? ADDR_W'(nt - TW'(i)) : '0;
        end
    end

    // sequencer FSM with registered outputs; fin/zero hold in IDLE so PEs keep C_out
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            t       <= '0;
            k       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            mac_clr <= 1'b0;
            rd_en   <= '0;
            addr    <= '0;
            fin_s   <= '0;
            zero_s  <= '0;
        end else begin
            case (state)
                IDLE: if (start && k_len != '0) begin
                    state   <= CLEAR;
                    k       <= k_len;
                    busy    <= 1'b1;
                    mac_clr <= 1'b1;
                    fin_s   <= '0;
                    zero_s  <= '0;
                end
                CLEAR: begin
                    state   <= FEED;
                    mac_clr <= 1'b0;
                    t       <= nt;
                    rd_en   <= nx_en;
                    addr    <= nx_addr;
                    fin_s   <= nx_fin;
                    zero_s  <= nx_zero;
                end
                FEED: if (nt == TW'(k) + TW'(N - 1)) begin
                    state  <= DRAIN;
                    t      <= '0;
                    rd_en  <= '0;
                    addr   <= '0;
                    fin_s  <= '1;
                    zero_s <= '1;
                end else begin
                    t      <= nt;
                    rd_en  <= nx_en;
                    addr   <= nx_addr;
                    fin_s  <= nx_fin;
                    zero_s <= nx_zero;
                end
                DRAIN: if (t == TW'(DL - 1)) begin
                    state <= DONE;
                    done  <= 1'b1;
                end else begin
                    t <= t + 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign a_rd_en   = rd_en;
    assign b_rd_en   = rd_en;
    assign a_rd_addr = addr;
    assign b_rd_addr = addr;

    lane_delay #(.W(2 * N), .LAT(RD_LAT)) u_row_dly (
        .clk (clk),
        .clr (rst | mac_clr),
        .d   ({fin_s, zero_s}),
        .q   ({a_fin, a_zero})
    );

    lane_delay #(.W(2 * N), .LAT(RD_LAT)) u_col_dly (
        .clk (clk),
        .clr (rst | mac_clr),
        .d   ({fin_s, zero_s}),
        .q   ({b_fin, b_zero})
    );
endmodule
